vector_lane_sequencer: RTL and testbench
========================================

# vector_lane_sequencer

Parametrised multi-beat vector execute unit. Successor to the single-cycle, six-element vector ALU path in the execute stage. Processes a VECTOR_SIZE-element vector through LANES parallel lane ALUs over ceil(VECTOR_SIZE/LANES) beats. Handshaked with decode and memory through valid/ready, and honours the pipeline flush.

## Interface
- DATA_WIDTH, 19: element width in bits.
- VECTOR_SIZE, 6: elements per vector; must be ≥1.
- LANES, 2: parallel lane ALUs; 1 ≤ LANES ≤ VECTOR_SIZE; need not divide VECTOR_SIZE.
- ALU_CTRL_WIDTH, 3: width of the ALU operation code.

- clock, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- flush, input, 1: synchronous abort of the in-flight operation.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: unit can accept.
- operand1, input, VECTOR_SIZE*DATA_WIDTH: vector A. Element i is at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- operand2, input, VECTOR_SIZE*DATA_WIDTH: vector B.
- scalar_operand, input, DATA_WIDTH: broadcast operand.
- use_scalar, input, 1: replace every B element with scalar_operand.
- alu_control, input, ALU_CTRL_WIDTH: operation code.
- mask, input, VECTOR_SIZE: per-element enable; bit i enables element i.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- result, output, VECTOR_SIZE*DATA_WIDTH: result vector.
- cmp_mask, output, VECTOR_SIZE: per-element compare outcome.
- out_zero, output, 1: every enabled result element is zero.

## Operation
- NBEATS = ceil(VECTOR_SIZE/LANES).
- FSM states and transitions:
  - IDLE → RUN on in_valid && in_ready. All inputs are captured into internal registers; the beat counter is set to 0.
  - RUN: beat k drives elements k*LANES .. k*LANES+LANES-1. In the last beat, lanes whose index is ≥ VECTOR_SIZE are idle and write nothing. The counter increments each cycle. RUN → DONE after beat NBEATS-1.
  - DONE: holds result, cmp_mask and out_zero stable. DONE → IDLE on out_ready.
- in_ready = (state==IDLE) && !reset && !flush.
- out_valid = (state==DONE).
- Operation codes (signed two's complement where relevant):
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 shift left logical, 110 shift right logical. The shift amount is B[$clog2(DATA_WIDTH)-1:0]. An amount ≥ DATA_WIDTH gives 0.
  - 111 signed less-than: the result element is 1 or 0 and the matching cmp_mask bit is set to the same outcome.
- cmp_mask is 0 for all operations other than 111 and for masked-off elements.
- Add and sub wrap modulo 2^DATA_WIDTH unless saturation is enabled (see Configuration).
- A masked-off element's result equals its A element unchanged.
- out_zero is evaluated over enabled elements only. It is 1 when the mask is all-zero.

## Timing
- Acceptance edge T0. Element results are registered at edges T1..T_NBEATS. out_valid is high from edge T_NBEATS until the cycle in which out_ready is sampled high.
- Latency: NBEATS cycles from acceptance to out_valid. Minimum initiation interval is NBEATS+2 cycles; there is no DONE→accept bypass.
- result, cmp_mask and out_zero change only at beat writes and reset. They keep their values after returning to IDLE.
- Reset (highest priority, any state): state=IDLE, counter=0, result=0, cmp_mask=0, out_zero=0, out_valid=0. in_ready is 0 while reset is high and 1 the cycle after.
- flush (second priority, any state): next state is IDLE. The in-flight operation is discarded and out_valid drops at the next edge. Partial results already written remain, but are not presented as valid. flush together with in_valid in IDLE means no accept.
- out_ready while not in DONE is ignored.
- Inputs are sampled only at acceptance, so they may change freely during RUN and DONE.

## Configuration
- VEC_SAT_EN defined: add and sub saturate to the signed range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. All other operations are unchanged.
- VEC_SAT_EN undefined: add and sub wrap. No saturation logic is instantiated.

## Structure
- Package vector_pkg:
  - alu_op_e enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SLT).
  - seq_state_e enum (IDLE, RUN, DONE).
  - nbeats(VECTOR_SIZE, LANES) function.
- Sub-module vector_lane_alu: combinational single-element ALU with inputs a, b, op and outputs y, lt, honouring VEC_SAT_EN. It is instantiated LANES times through a generate loop.
- The top level holds the FSM, beat counter, operand capture registers, lane muxing and result assembly.

## Test plan
- Add, VECTOR_SIZE=6, LANES=2, A=1..6, B=10, use_scalar=1, mask=111111 → after 3 cycles out_valid, result=11..16, cmp_mask=0, out_zero=0.
- Masked sub, A=5 in all elements, B=5, mask=010101 → enabled elements 0, masked elements 5, out_zero=1.
- Remainder, VECTOR_SIZE=6, LANES=4, SLT with A=-1,0,1,2,3,4 and B=1 → NBEATS=2, cmp_mask=000011, result elements 1,1,0,0,0,0.
- flush asserted in the second RUN cycle → IDLE next edge, out_valid never rises, in_ready=1 the following cycle, next op completes correctly.
- Backpressure: out_ready held low for 5 cycles in DONE → result stable, in_ready=0 throughout; accept completes on out_ready=1.
- With VEC_SAT_EN, DATA_WIDTH=19: 262143+1 → 262143; -262144-1 → -262144. Without the macro: 262143+1 → -262144.

Source files
------------

// File: rtl/vector_lane_sequencer_pkg.sv
// Shared types and helpers for the multi-beat vector lane sequencer.
package vector_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        SLL = 3'b101,
        SRL = 3'b110,
        SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    function automatic int nbeats(input int vector_size, input int lanes);
        return (vector_size + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/vector_lane_sequencer_if.sv
// Decode/memory-facing handshake bundle of the vector lane sequencer.
interface vector_lane_sequencer_if #(
    parameter int DATA_WIDTH     = 19,
    parameter int VECTOR_SIZE    = 6,
    parameter int ALU_CTRL_WIDTH = 3
);
    logic                              in_valid;
    logic                              in_ready;
    logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand1;
    logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand2;
    logic [DATA_WIDTH-1:0]             scalar_operand;
    logic                              use_scalar;
    logic [ALU_CTRL_WIDTH-1:0]         alu_control;
    logic [VECTOR_SIZE-1:0]            mask;
    logic                              out_valid;
    logic                              out_ready;
    logic [VECTOR_SIZE*DATA_WIDTH-1:0] result;
    logic [VECTOR_SIZE-1:0]            cmp_mask;
    logic                              out_zero;

    modport master (
        output in_valid, operand1, operand2, scalar_operand, use_scalar,
               alu_control, mask, out_ready,
        input  in_ready, out_valid, result, cmp_mask, out_zero
    );

    modport slave (
        input  in_valid, operand1, operand2, scalar_operand, use_scalar,
               alu_control, mask, out_ready,
        output in_ready, out_valid, result, cmp_mask, out_zero
    );
endinterface

// File: rtl/vector_lane_sequencer_alu.sv
// Combinational single-element lane ALU.
// Build option: define VEC_SAT_EN to saturate add/sub to the signed range.
module vector_lane_alu
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH = 19
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  alu_op_e               op,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  lt
);
    localparam int SH_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [SH_W-1:0]       shamt;
    logic [DATA_WIDTH-1:0] add_res;
    logic [DATA_WIDTH-1:0] sub_res;

    assign shamt = b[SH_W-1:0];
    assign lt    = $signed(a) < $signed(b);

`ifdef VEC_SAT_EN
    logic [DATA_WIDTH:0] sum_ext;
    logic [DATA_WIDTH:0] diff_ext;

    // One guard bit: overflow when it disagrees with the result sign bit.
    function automatic logic [DATA_WIDTH-1:0] sat(input logic [DATA_WIDTH:0] v);
        if (v[DATA_WIDTH] != v[DATA_WIDTH-1])
            return v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return v[DATA_WIDTH-1:0];
    endfunction

    assign sum_ext  = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    assign diff_ext = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    assign add_res  = sat(sum_ext);
    assign sub_res  = sat(diff_ext);
`else
    assign add_res = a + b;
    assign sub_res = a - b;
`endif

    always_comb begin
        y = '0;
        case (op)
            ADD: y = add_res;
            SUB: y = sub_res;
            AND: y = a & b;
            OR:  y = a | b;
            XOR: y = a ^ b;
            SLL: y = (32'(shamt) >= 32'(DATA_WIDTH)) ? '0 : (a << shamt);
            SRL: y = (32'(shamt) >= 32'(DATA_WIDTH)) ? '0 : (a >> shamt);
            SLT: y = DATA_WIDTH'(lt);
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/vector_lane_sequencer.sv
// Multi-beat vector execute unit: LANES lane ALUs swept over VECTOR_SIZE elements.
// Add/sub saturation is selected at build time with VEC_SAT_EN (see vector_lane_alu).
//   state | meaning
//   IDLE  | waiting for operands; in_ready high unless reset/flush
//   RUN   | one beat of LANES elements written per cycle
//   DONE  | result presented with out_valid until out_ready
module vector_lane_sequencer
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH     = 19,
    parameter int VECTOR_SIZE    = 6,
    parameter int LANES          = 2,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input logic clock,
    input logic reset,
    input logic flush,
    vector_lane_sequencer_if.slave bus
);
    localparam int NBEATS = nbeats(VECTOR_SIZE, LANES);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int VEC_W  = VECTOR_SIZE * DATA_WIDTH;

    seq_state_e             state_q,  state_d;
    logic [BEAT_W-1:0]      beat_q,   beat_d;
    logic [VEC_W-1:0]       a_q,      a_d;
    logic [VEC_W-1:0]       b_q,      b_d;
    alu_op_e                op_q,     op_d;
    logic [VECTOR_SIZE-1:0] mask_q,   mask_d;
    logic [VEC_W-1:0]       result_q, result_d;
    logic [VECTOR_SIZE-1:0] cmp_q,    cmp_d;
    logic                   zero_q,   zero_d;

    logic [DATA_WIDTH-1:0]  lane_a [LANES];
    logic [DATA_WIDTH-1:0]  lane_b [LANES];
    logic [DATA_WIDTH-1:0]  lane_y [LANES];
    logic                   lane_lt[LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int lane_idx;
        assign lane_idx  = int'(beat_q) * LANES + l;
        assign lane_a[l] = (lane_idx < VECTOR_SIZE) ? a_q[lane_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign lane_b[l] = (lane_idx < VECTOR_SIZE) ? b_q[lane_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

        vector_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
            .a  (lane_a[l]),
            .b  (lane_b[l]),
            .op (op_q),
            .y  (lane_y[l]),
            .lt (lane_lt[l])
        );
    end

    assign bus.in_ready  = (state_q == IDLE) && !reset && !flush;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cmp_mask  = cmp_q;
    assign bus.out_zero  = zero_q;

    always_comb begin
        int  idx;
        logic beat_zero;
        idx       = 0;
        beat_zero = 1'b1;
        state_d   = state_q;
        beat_d    = beat_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        mask_d    = mask_q;
        result_d  = result_q;
        cmp_d     = cmp_q;
        zero_d    = zero_q;

        if (flush) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_d     = bus.operand1;
                        b_d     = bus.use_scalar ? {VECTOR_SIZE{bus.scalar_operand}} : bus.operand2;
                        op_d    = alu_op_e'(bus.alu_control);
                        mask_d  = bus.mask;
                        beat_d  = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        idx = int'(beat_q) * LANES + l;
                        if (idx < VECTOR_SIZE) begin
                            result_d[idx*DATA_WIDTH +: DATA_WIDTH] = mask_q[idx] ? lane_y[l]
                                : a_q[idx*DATA_WIDTH +: DATA_WIDTH];
                            cmp_d[idx] = mask_q[idx] && (op_q == SLT) && lane_lt[l];
                            if (mask_q[idx] && (lane_y[l] != '0))
                                beat_zero = 1'b0;
                        end
                    end
                    // First beat restarts the zero accumulation.
                    zero_d = ((beat_q == '0) ? 1'b1 : zero_q) & beat_zero;
                    if (beat_q == BEAT_W'(NBEATS - 1)) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ADD;
            mask_q   <= '0;
            result_q <= '0;
            cmp_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            cmp_q    <= cmp_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed self-checking bench: a 2-lane and a 4-lane sequencer, 6 x 19-bit vectors.
module tb_vector_lane_sequencer;
    localparam int DW = 19;
    localparam int VS = 6;
    localparam int W  = VS * DW;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    vector_lane_sequencer_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ALU_CTRL_WIDTH(3)) bus_a ();
    vector_lane_sequencer_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ALU_CTRL_WIDTH(3)) bus_b ();

    vector_lane_sequencer #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .LANES(2), .ALU_CTRL_WIDTH(3)) dut_a (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus_a)
    );

    vector_lane_sequencer #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .LANES(4), .ALU_CTRL_WIDTH(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input logic [DW-1:0] e0, e1, e2, e3, e4, e5);
        return {e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic issue_a(input logic [W-1:0] a, input logic [W-1:0] b, input logic [DW-1:0] s,
                           input logic us, input logic [2:0] op, input logic [VS-1:0] m);
        bus_a.operand1       = a;
        bus_a.operand2       = b;
        bus_a.scalar_operand = s;
        bus_a.use_scalar     = us;
        bus_a.alu_control    = op;
        bus_a.mask           = m;
        bus_a.in_valid       = 1'b1;
        @(posedge clock); #1;
        bus_a.in_valid       = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int cnt = 0;
        while (bus_a.out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clock); #1;
            cnt++;
        end
        check(tag, cnt, 3);
    endtask

    task automatic release_a(input string tag);
        bus_a.out_ready = 1'b1;
        @(posedge clock); #1;
        bus_a.out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, bus_a.out_valid, 1'b0);
        check({tag, "_iready_back"}, bus_a.in_ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] exp_v;
        int           cnt;
        int           bad;

        reset = 1'b1;
        flush = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.operand1 = '0; bus_a.operand2 = '0;
        bus_a.scalar_operand = '0; bus_a.use_scalar = 1'b0; bus_a.alu_control = '0; bus_a.mask = '0;
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.operand1 = '0; bus_b.operand2 = '0;
        bus_b.scalar_operand = '0; bus_b.use_scalar = 1'b0; bus_b.alu_control = '0; bus_b.mask = '0;

        repeat (2) begin @(posedge clock); #1; end
        check("rst_iready",  bus_a.in_ready,  1'b0);
        check("rst_ovalid",  bus_a.out_valid, 1'b0);
        check("rst_result",  bus_a.result,    '0);
        check("rst_cmp",     bus_a.cmp_mask,  '0);
        check("rst_zero",    bus_a.out_zero,  1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_iready", bus_a.in_ready, 1'b1);

        // add with broadcast scalar
        issue_a(pk(1, 2, 3, 4, 5, 6), '0, 19'd10, 1'b1, 3'b000, 6'b111111);
        check("add_busy_iready", bus_a.in_ready, 1'b0);
        wait_done_a("add_latency");
        check("add_result", bus_a.result,   pk(11, 12, 13, 14, 15, 16));
        check("add_cmp",    bus_a.cmp_mask, 6'b000000);
        check("add_zero",   bus_a.out_zero, 1'b0);
        release_a("add");

        // masked sub
        issue_a(pk(5, 5, 5, 5, 5, 5), pk(5, 5, 5, 5, 5, 5), '0, 1'b0, 3'b001, 6'b010101);
        wait_done_a("sub_latency");
        check("sub_result", bus_a.result,   pk(0, 5, 0, 5, 0, 5));
        check("sub_cmp",    bus_a.cmp_mask, 6'b000000);
        check("sub_zero",   bus_a.out_zero, 1'b1);
        release_a("sub");

        // flush in the second RUN cycle: only beat 0 lands
        issue_a(pk(1, 1, 1, 1, 1, 1), '0, 19'h00100, 1'b1, 3'b011, 6'b111111);
        @(posedge clock); #1;
        flush = 1'b1;
        #1;
        check("flush_iready_low", bus_a.in_ready, 1'b0);
        @(posedge clock); #1;
        flush = 1'b0;
        #1;
        check("flush_ovalid", bus_a.out_valid, 1'b0);
        check("flush_iready", bus_a.in_ready,  1'b1);
        check("flush_partial", bus_a.result,   pk(19'h101, 19'h101, 0, 5, 0, 5));
        cnt = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (bus_a.out_valid !== 1'b0) cnt++;
        end
        check("flush_no_valid", cnt, 0);

        // and after flush
        issue_a({VS{19'h7FFFF}}, pk(0, 3, 6, 9, 12, 15), '0, 1'b0, 3'b010, 6'b111111);
        wait_done_a("and_latency");
        check("and_result", bus_a.result,   pk(0, 3, 6, 9, 12, 15));
        check("and_zero",   bus_a.out_zero, 1'b0);
        release_a("and");

        // sll with boundary amounts, then held in DONE for 5 cycles
        issue_a(pk(1, 1, 1, 1, 1, 1), pk(0, 1, 18, 19, 31, 5), '0, 1'b0, 3'b101, 6'b111111);
        wait_done_a("sll_latency");
        exp_v = pk(1, 2, 19'h40000, 0, 0, 32);
        check("sll_result", bus_a.result, exp_v);
        bad = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (bus_a.result !== exp_v || bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1) bad++;
        end
        check("backpressure_hold", bad, 0);
        release_a("sll");

        // srl, element 0 masked off
        issue_a({VS{19'h40000}}, pk(0, 1, 18, 19, 3, 17), '0, 1'b0, 3'b110, 6'b111110);
        wait_done_a("srl_latency");
        check("srl_result", bus_a.result, pk(19'h40000, 19'h20000, 1, 0, 19'h08000, 2));
        check("srl_zero",   bus_a.out_zero, 1'b0);
        release_a("srl");

        // signed range edges for add/sub
        issue_a(pk(19'h3FFFF, 19'h40000, 0, 0, 0, 0), pk(1, 19'h7FFFF, 0, 0, 0, 0), '0, 1'b0, 3'b000, 6'b000011);
        wait_done_a("edge_add_latency");
`ifdef VEC_SAT_EN
        check("edge_add", bus_a.result, pk(19'h3FFFF, 19'h40000, 0, 0, 0, 0));
`else
        check("edge_add", bus_a.result, pk(19'h40000, 19'h3FFFF, 0, 0, 0, 0));
`endif
        release_a("edge_add");

        issue_a(pk(19'h40000, 19'h3FFFF, 0, 0, 0, 0), pk(1, 19'h7FFFF, 0, 0, 0, 0), '0, 1'b0, 3'b001, 6'b000011);
        wait_done_a("edge_sub_latency");
`ifdef VEC_SAT_EN
        check("edge_sub", bus_a.result, pk(19'h40000, 19'h3FFFF, 0, 0, 0, 0));
`else
        check("edge_sub", bus_a.result, pk(19'h3FFFF, 19'h40000, 0, 0, 0, 0));
`endif
        release_a("edge_sub");

        // 4 lanes over 6 elements: remainder beat, out_ready held high from the start
        bus_b.operand1       = pk(19'h7FFFF, 0, 1, 2, 3, 4);
        bus_b.scalar_operand = 19'd1;
        bus_b.use_scalar     = 1'b1;
        bus_b.alu_control    = 3'b111;
        bus_b.mask           = 6'b111111;
        bus_b.out_ready      = 1'b1;
        bus_b.in_valid       = 1'b1;
        @(posedge clock); #1;
        bus_b.in_valid       = 1'b0;
        cnt = 0;
        while (bus_b.out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clock); #1;
            cnt++;
        end
        check("slt_latency", cnt, 2);
        check("slt_result",  bus_b.result,   pk(1, 1, 0, 0, 0, 0));
        check("slt_cmp",     bus_b.cmp_mask, 6'b000011);
        check("slt_zero",    bus_b.out_zero, 1'b0);
        @(posedge clock); #1;
        bus_b.out_ready = 1'b0;
        check("slt_ovalid_drop", bus_b.out_valid, 1'b0);
        check("slt_result_kept", bus_b.result,    pk(1, 1, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
